// File: rtl/program_sequencer.sv
// Fetch-side program sequencer: holds the program counter, forms the next
// program-memory address from decoder jump requests, and stretches the board reset.
module program_sequencer #(
    parameter int PC_WIDTH      = 8,
    parameter int RESET_STRETCH = 4
) (
    input  logic                clk,
    input  logic                async_reset_n,
    input  logic                jmp,
    input  logic                jmp_nz,
    input  logic [3:0]          ir_nibble,
    input  logic                zero_flag,
    output logic [PC_WIDTH-1:0] pm_addr,
    output logic [PC_WIDTH-1:0] pc,
    output logic                sync_reset,
    output logic                jump_taken
);

    localparam logic [3:0] STRETCH = 4'(RESET_STRETCH);

    logic                r_rs1;
    logic                r_rs2;
    logic [3:0]          r_rcnt;
    logic                r_sync_reset;
    logic [PC_WIDTH-1:0] r_pc;

    logic [PC_WIDTH-1:0] w_pm_addr;
    logic [PC_WIDTH-1:0] w_jump_target;
    logic                w_jump_taken;

    // Assert is immediate; release only reaches rs2 after two clock edges.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, which is what makes rs1 -> rs2 a real two-stage chain.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_rs1 <= 1'b0;
            r_rs2 <= 1'b0;
        end else begin
            r_rs1 <= 1'b1;
            r_rs2 <= r_rs1;
        end
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_rcnt <= 4'd0;
        end else if (!r_rs2) begin
            r_rcnt <= 4'd0;
        end else if (r_rcnt < STRETCH) begin
            r_rcnt <= r_rcnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_sync_reset <= 1'b1;
        end else if (r_rcnt == STRETCH) begin
            r_sync_reset <= 1'b0;
        end
    end

    // Jumps only replace the low nibble, so the target stays in the current 16-word page.
    assign w_jump_target = {r_pc[PC_WIDTH-1:4], ir_nibble};

    // NOTE: defaults come first so every path assigns every output and no latch is inferred.
    always_comb begin
        w_pm_addr    = r_pc + PC_WIDTH'(1);
        w_jump_taken = 1'b0;
        if (r_sync_reset) begin
            w_pm_addr    = '0;
            w_jump_taken = 1'b0;
        end else if (jmp) begin
            w_pm_addr    = w_jump_target;
            w_jump_taken = 1'b1;
        end else if (jmp_nz && !zero_flag) begin
            w_pm_addr    = w_jump_target;
            w_jump_taken = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pm_addr;
        end
    end

    assign pm_addr    = w_pm_addr;
    assign pc         = r_pc;
    assign sync_reset = r_sync_reset;
    assign jump_taken = w_jump_taken;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: reset stretch, sequential fetch, jumps,
// jump priority/page rules and asynchronous reset mid-run.
module tb_program_sequencer;

    logic       clk;
    logic       async_reset_n;
    logic       jmp;
    logic       jmp_nz;
    logic [3:0] ir_nibble;
    logic       zero_flag;
    logic [7:0] pm_addr;
    logic [7:0] pc;
    logic       sync_reset;
    logic       jump_taken;

    int total;
    int bad;

    program_sequencer #(
        .PC_WIDTH      (8),
        .RESET_STRETCH (4)
    ) dut (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .jmp           (jmp),
        .jmp_nz        (jmp_nz),
        .ir_nibble     (ir_nibble),
        .zero_flag     (zero_flag),
        .pm_addr       (pm_addr),
        .pc            (pc),
        .sync_reset    (sync_reset),
        .jump_taken    (jump_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        jmp       = 1'b0;
        jmp_nz    = 1'b0;
        ir_nibble = 4'h0;
        zero_flag = 1'b0;
    endtask

    // Step with no jumps until pc reaches target, bounded.
    task automatic advance_to(input logic [7:0] target);
        int n;
        n = 0;
        idle_inputs();
        #1;
        while (pc !== target && n < 300) begin
            step();
            n++;
        end
        total++;
        if (pc !== target) begin
            bad++;
            $display("FAIL advance_to: pc=%0h required %0h", pc, target);
        end
    endtask

    // async_reset_n has just risen between edges; next edge is E0.
    task automatic check_release();
        logic exp_sr;
        for (int k = 0; k <= 6; k++) begin
            step();
            exp_sr = (k <= 5);
            total++;
            if (sync_reset !== exp_sr) begin
                bad++;
                $display("FAIL release_sync_reset E%0d: got %b required %b", k, sync_reset, exp_sr);
            end
            total++;
            if (pc !== 8'h00) begin
                bad++;
                $display("FAIL release_pc E%0d: got %0h required 0", k, pc);
            end
            if (k <= 5) begin
                total++;
                if (pm_addr !== 8'h00 || jump_taken !== 1'b0) begin
                    bad++;
                    $display("FAIL release_pm_addr E%0d: got %0h/%b required 0/0", k, pm_addr, jump_taken);
                end
            end
            if (k == 5) begin
                idle_inputs();
                #1;
            end
        end
        total++;
        if (pm_addr !== 8'h01 || jump_taken !== 1'b0) begin
            bad++;
            $display("FAIL first_fetch: pm_addr=%0h jt=%b required 01/0", pm_addr, jump_taken);
        end
    endtask

    task automatic check_in_reset(input string name);
        total++;
        if (sync_reset !== 1'b1 || pc !== 8'h00 || pm_addr !== 8'h00 || jump_taken !== 1'b0) begin
            bad++;
            $display("FAIL %s: sr=%b pc=%0h pm=%0h jt=%b required 1/0/0/0",
                     name, sync_reset, pc, pm_addr, jump_taken);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        async_reset_n = 1'b1;
        #12;
        async_reset_n = 1'b0;
        #1;
        jmp       = 1'bx;
        jmp_nz    = 1'bx;
        ir_nibble = 4'hx;
        zero_flag = 1'bx;
        #1;
        check_in_reset("reset_assert");
        step();
        step();
        check_in_reset("reset_held_x_inputs");
        @(negedge clk);
        async_reset_n = 1'b1;
        check_release();
    endtask

    task automatic test_sequential();
        logic [7:0] exp_pm;
        logic [7:0] exp_pc;
        int errs;
        errs = 0;
        for (int i = 0; i < 260; i++) begin
            exp_pm = 8'((i + 1) & 8'hFF);
            exp_pc = 8'(i & 8'hFF);
            total++;
            if (pm_addr !== exp_pm || pc !== exp_pc || jump_taken !== 1'b0) begin
                bad++;
                errs++;
                if (errs < 5)
                    $display("FAIL seq_%0d: pm=%0h pc=%0h jt=%b required %0h/%0h/0",
                             i, pm_addr, pc, jump_taken, exp_pm, exp_pc);
            end
            step();
        end
    endtask

    task automatic test_jump();
        advance_to(8'h37);
        jmp       = 1'b1;
        ir_nibble = 4'hA;
        #1;
        total++;
        if (pm_addr !== 8'h3A || jump_taken !== 1'b1) begin
            bad++;
            $display("FAIL jmp_target: pm=%0h jt=%b required 3a/1", pm_addr, jump_taken);
        end
        step();
        idle_inputs();
        #1;
        total++;
        if (pc !== 8'h3A || pm_addr !== 8'h3B || jump_taken !== 1'b0) begin
            bad++;
            $display("FAIL jmp_landed: pc=%0h pm=%0h jt=%b required 3a/3b/0", pc, pm_addr, jump_taken);
        end
    endtask

    task automatic test_cond_jump();
        advance_to(8'h52);
        jmp_nz    = 1'b1;
        ir_nibble = 4'h0;
        zero_flag = 1'b0;
        #1;
        total++;
        if (pm_addr !== 8'h50 || jump_taken !== 1'b1) begin
            bad++;
            $display("FAIL jnz_taken: pm=%0h jt=%b required 50/1", pm_addr, jump_taken);
        end
        zero_flag = 1'b1;
        #1;
        total++;
        if (pm_addr !== 8'h53 || jump_taken !== 1'b0) begin
            bad++;
            $display("FAIL jnz_not_taken: pm=%0h jt=%b required 53/0", pm_addr, jump_taken);
        end
        step();
        idle_inputs();
        #1;
        total++;
        if (pc !== 8'h53) begin
            bad++;
            $display("FAIL jnz_fallthrough_pc: got %0h required 53", pc);
        end
    endtask

    task automatic test_priority_page();
        advance_to(8'hF3);
        jmp       = 1'b1;
        jmp_nz    = 1'b1;
        zero_flag = 1'b1;
        ir_nibble = 4'h3;
        #1;
        total++;
        if (pm_addr !== 8'hF3 || jump_taken !== 1'b1) begin
            bad++;
            $display("FAIL priority_self_loop: pm=%0h jt=%b required f3/1", pm_addr, jump_taken);
        end
        step();
        step();
        total++;
        if (pc !== 8'hF3 || pm_addr !== 8'hF3) begin
            bad++;
            $display("FAIL tight_loop: pc=%0h pm=%0h required f3/f3", pc, pm_addr);
        end
        jmp_nz    = 1'b0;
        zero_flag = 1'b0;
        ir_nibble = 4'hF;
        #1;
        total++;
        if (pm_addr !== 8'hFF || jump_taken !== 1'b1) begin
            bad++;
            $display("FAIL page_f_jump: pm=%0h jt=%b required ff/1", pm_addr, jump_taken);
        end
        step();
        idle_inputs();
        #1;
        total++;
        if (pc !== 8'hFF || pm_addr !== 8'h00) begin
            bad++;
            $display("FAIL wrap_after_jump: pc=%0h pm=%0h required ff/00", pc, pm_addr);
        end
    endtask

    task automatic test_reset_midrun();
        advance_to(8'h44);
        #2;
        async_reset_n = 1'b0;
        #1;
        check_in_reset("midrun_assert");
        jmp       = 1'bx;
        jmp_nz    = 1'bx;
        ir_nibble = 4'hx;
        zero_flag = 1'bx;
        #1;
        check_in_reset("midrun_x_inputs");
        @(negedge clk);
        async_reset_n = 1'b1;
        check_release();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        async_reset_n = 1'b1;
        idle_inputs();
        test_reset();
        test_sequential();
        test_jump();
        test_cond_jump();
        test_priority_page();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
